// File: rtl/branch_stat_unit.sv
// Branch statistics block: three saturating event counters read over a 16-bit port with a hi/lo snapshot.
// Optional macro BR_STAT_IRQ_EN adds the stat_irq output and the CTRL irq_mask bit.
module branch_stat_unit #(
    parameter int CNT_W  = 32,
    parameter bit EN_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_br_cnt,
    input  logic        inc_hit_cnt,
    input  logic        inc_mispr_cnt,
    input  logic [2:0]  addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdata_vld
`ifdef BR_STAT_IRQ_EN
    ,
    output logic        stat_irq
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [2:0] A_BR_LO    = 3'd0;
    localparam logic [2:0] A_BR_HI    = 3'd1;
    localparam logic [2:0] A_HIT_LO   = 3'd2;
    localparam logic [2:0] A_HIT_HI   = 3'd3;
    localparam logic [2:0] A_MISPR_LO = 3'd4;
    localparam logic [2:0] A_MISPR_HI = 3'd5;
    localparam logic [2:0] A_CTRL     = 3'd6;
    localparam logic [2:0] A_STATUS   = 3'd7;

    // Upper counter bits, zero-extended so narrower counters read as zero above CNT_W.
    function automatic logic [15:0] hi_part(input logic [CNT_W-1:0] c);
        return 16'(32'(c) >> 16);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                   input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (c != CNT_MAX))
            return c + CNT_W'(1);
        return c;
    endfunction

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] mispr_cnt_q, mispr_cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [2:0]       sat_q, sat_d;
    logic             enable_q, enable_d;
    logic             freeze_q, freeze_d;
    logic             irq_mask_q, irq_mask_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             rdata_vld_q, rdata_vld_d;
    logic             stat_irq_q, stat_irq_d;

    logic             wr_ctrl, clr_all, cnt_en;
    logic             inc_br, inc_hit, inc_mispr;

    always_comb begin
        wr_ctrl   = we && (addr == A_CTRL);
        clr_all   = we && (addr == A_STATUS) && wdata[0];
        cnt_en    = enable_q && !freeze_q;
        inc_br    = inc_br_cnt    && cnt_en;
        inc_hit   = inc_hit_cnt   && cnt_en;
        inc_mispr = inc_mispr_cnt && cnt_en;

        br_cnt_d    = cnt_next(br_cnt_q,    inc_br,    clr_all);
        hit_cnt_d   = cnt_next(hit_cnt_q,   inc_hit,   clr_all);
        mispr_cnt_d = cnt_next(mispr_cnt_q, inc_mispr, clr_all);

        // A flag sticks once a strobe arrives while its counter is already pinned at all-ones.
        sat_d = sat_q | {inc_mispr && (mispr_cnt_q == CNT_MAX),
                         inc_hit   && (hit_cnt_q   == CNT_MAX),
                         inc_br    && (br_cnt_q    == CNT_MAX)};
        if (clr_all)
            sat_d = '0;

        enable_d   = wr_ctrl ? wdata[0] : enable_q;
        freeze_d   = wr_ctrl ? wdata[1] : freeze_q;
`ifdef BR_STAT_IRQ_EN
        irq_mask_d = wr_ctrl ? wdata[2] : irq_mask_q;
        stat_irq_d = clr_all ? 1'b0 : ((|sat_q) && irq_mask_q);
`else
        irq_mask_d = 1'b0;
        stat_irq_d = 1'b0;
`endif

        shadow_d    = shadow_q;
        rdata_d     = rdata_q;
        rdata_vld_d = re;
        if (re) begin
            case (addr)
                A_BR_LO: begin
                    rdata_d  = br_cnt_q[15:0];
                    shadow_d = hi_part(br_cnt_q);
                end
                A_HIT_LO: begin
                    rdata_d  = hit_cnt_q[15:0];
                    shadow_d = hi_part(hit_cnt_q);
                end
                A_MISPR_LO: begin
                    rdata_d  = mispr_cnt_q[15:0];
                    shadow_d = hi_part(mispr_cnt_q);
                end
                A_BR_HI, A_HIT_HI, A_MISPR_HI: rdata_d = shadow_q;
                A_CTRL:   rdata_d = {13'd0, irq_mask_q, freeze_q, enable_q};
                A_STATUS: rdata_d = {13'd0, sat_q};
                default:  rdata_d = rdata_q;
            endcase
        end
        // Clear-all beats a same-cycle LO snapshot.
        if (clr_all)
            shadow_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q    <= '0;
            hit_cnt_q   <= '0;
            mispr_cnt_q <= '0;
            shadow_q    <= '0;
            sat_q       <= '0;
            enable_q    <= EN_RST;
            freeze_q    <= 1'b0;
            irq_mask_q  <= 1'b0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
            stat_irq_q  <= 1'b0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            mispr_cnt_q <= mispr_cnt_d;
            shadow_q    <= shadow_d;
            sat_q       <= sat_d;
            enable_q    <= enable_d;
            freeze_q    <= freeze_d;
            irq_mask_q  <= irq_mask_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
            stat_irq_q  <= stat_irq_d;
        end
    end

    assign rdata     = rdata_q;
    assign rdata_vld = rdata_vld_q;

`ifdef BR_STAT_IRQ_EN
    assign stat_irq = stat_irq_q;
    logic unused_wdata;
    assign unused_wdata = ^wdata[15:3];
`else
    logic unused_wdata;
    assign unused_wdata = ^{wdata[15:2], stat_irq_q};
`endif

endmodule

// File: tb/tb_branch_stat_unit.sv
// Directed bench for branch_stat_unit: reset, counting, hi/lo snapshot, saturation, freeze, clear and reset mid-read.
module tb_branch_stat_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inc_br_cnt = 1'b0;
    logic        inc_hit_cnt = 1'b0;
    logic        inc_mispr_cnt = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        rdata_vld;
`ifdef BR_STAT_IRQ_EN
    logic        stat_irq;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    branch_stat_unit dut (
        .clk          (clk),
        .rst          (rst),
        .inc_br_cnt   (inc_br_cnt),
        .inc_hit_cnt  (inc_hit_cnt),
        .inc_mispr_cnt(inc_mispr_cnt),
        .addr         (addr),
        .re           (re),
        .we           (we),
        .wdata        (wdata),
        .rdata        (rdata),
        .rdata_vld    (rdata_vld)
`ifdef BR_STAT_IRQ_EN
        ,
        .stat_irq     (stat_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access cycle: drive at a falling edge, let one rising edge sample it, return at the next falling edge.
    task automatic drive(input logic w, input logic r, input logic [2:0] a,
                         input logic [15:0] d, input logic [2:0] s);
        @(negedge clk);
        we = w; re = r; addr = a; wdata = d;
        {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = s;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wdata = 16'h0;
        {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b000;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] s, input logic [15:0] exp, input string tag);
        drive(1'b0, 1'b1, a, 16'h0, s);
        check({tag, "_vld"}, 32'(rdata_vld), 32'd1);
        check(tag, 32'(rdata), 32'(exp));
        @(negedge clk);
        check({tag, "_vld_drop"}, 32'(rdata_vld), 32'd0);
        check({tag, "_hold"}, 32'(rdata), 32'(exp));
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        drive(1'b1, 1'b0, a, d, 3'b000);
    endtask

    task automatic pulse(input logic [2:0] s, input int n);
        @(negedge clk);
        {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = s;
        repeat (n) @(negedge clk);
        {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b000;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_vld", 32'(rdata_vld), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) rd(3'(i), 3'b000, 16'h0000, $sformatf("rst_reg%0d", i));
        rd(3'd6, 3'b000, 16'h0001, "rst_ctrl");
        rd(3'd7, 3'b000, 16'h0000, "rst_status");

        // 10 branches, 4 hits, 1 mispredict
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inc_br_cnt    = 1'b1;
            inc_hit_cnt   = (i < 4);
            inc_mispr_cnt = (i == 5);
        end
        @(negedge clk);
        {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b000;
        rd(3'd0, 3'b000, 16'd10, "br_lo");
        rd(3'd1, 3'b000, 16'd0,  "br_hi");
        rd(3'd2, 3'b000, 16'd4,  "hit_lo");
        rd(3'd3, 3'b000, 16'd0,  "hit_hi");
        rd(3'd4, 3'b000, 16'd1,  "mispr_lo");
        rd(3'd5, 3'b000, 16'd0,  "mispr_hi");

        // Carry into the upper half and snapshot coherence
        @(negedge clk);
        force dut.br_cnt_d = 32'h0000_FFFF;
        @(negedge clk);
        release dut.br_cnt_d;
        pulse(3'b001, 1);
        rd(3'd0, 3'b000, 16'h0000, "carry_lo");
        pulse(3'b001, 1);
        rd(3'd1, 3'b000, 16'h0001, "carry_hi");
        rd(3'd0, 3'b001, 16'h0001, "lo_pre_inc");
        rd(3'd1, 3'b000, 16'h0001, "hi_pre_inc");
        rd(3'd0, 3'b000, 16'h0002, "lo_post_inc");

        // Saturation, ignored counter write, irq mask
        wr(3'd6, 16'h0005);
`ifdef BR_STAT_IRQ_EN
        rd(3'd6, 3'b000, 16'h0005, "ctrl_mask");
`else
        rd(3'd6, 3'b000, 16'h0001, "ctrl_nomask");
`endif
        @(negedge clk);
        force dut.hit_cnt_d = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_cnt_d;
        pulse(3'b010, 3);
        rd(3'd2, 3'b000, 16'hFFFF, "sat_lo");
        rd(3'd3, 3'b000, 16'hFFFF, "sat_hi");
        rd(3'd7, 3'b000, 16'h0002, "sat_status");
        wr(3'd2, 16'h1234);
        rd(3'd2, 3'b000, 16'hFFFF, "ro_write");
`ifdef BR_STAT_IRQ_EN
        check("irq_set", 32'(stat_irq), 32'd1);
`endif
        wr(3'd7, 16'h0001);
        rd(3'd3, 3'b000, 16'h0000, "clr_shadow");
        rd(3'd2, 3'b000, 16'h0000, "clr_hit");
        rd(3'd7, 3'b000, 16'h0000, "clr_status");
        rd(3'd0, 3'b000, 16'h0000, "clr_br");
`ifdef BR_STAT_IRQ_EN
        check("irq_clr", 32'(stat_irq), 32'd0);
`endif
        wr(3'd6, 16'h0001);

        // Freeze, clear-vs-strobe, read+write collision, disable
        pulse(3'b001, 2);
        wr(3'd6, 16'h0003);
        pulse(3'b111, 5);
        rd(3'd0, 3'b000, 16'd2, "frz_br");
        rd(3'd4, 3'b000, 16'd0, "frz_mispr");
        wr(3'd6, 16'h0001);
        pulse(3'b100, 1);
        rd(3'd4, 3'b000, 16'd1, "unfrz_mispr");
        drive(1'b1, 1'b0, 3'd7, 16'h0001, 3'b100);
        rd(3'd4, 3'b000, 16'd0, "clr_wins");
        drive(1'b1, 1'b1, 3'd6, 16'h0000, 3'b000);
        check("rw_vld", 32'(rdata_vld), 32'd1);
        check("rw_pre", 32'(rdata), 32'h0001);
        rd(3'd6, 3'b000, 16'h0000, "rw_post");
        pulse(3'b001, 1);
        rd(3'd0, 3'b000, 16'd0, "dis_br");
        wr(3'd6, 16'h0001);

        // Reset arriving while a read response is outstanding
        pulse(3'b111, 1);
        @(negedge clk);
        re = 1'b1; addr = 3'd0;
        @(posedge clk);
        #2;
        re = 1'b0;
        check("pend_vld", 32'(rdata_vld), 32'd1);
        check("pend_rdata", 32'(rdata), 32'h0001);
        rst = 1'b1;
        #1;
        check("arst_vld", 32'(rdata_vld), 32'd0);
        check("arst_rdata", 32'(rdata), 32'd0);
        check("arst_br", dut.br_cnt_q, 32'd0);
        check("arst_hit", dut.hit_cnt_q, 32'd0);
        check("arst_mispr", dut.mispr_cnt_q, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(3'd6, 3'b000, 16'h0001, "arst_ctrl");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_stat_unit.md
Name: branch_stat_unit

Overview:
- Downstream consumer of the branch target buffer's stat strobes (inc_br_cnt, inc_hit_cnt, inc_mispr_cnt).
- Holds three saturating event counters: branches reaching EX, BTB hits, and mispredictions.
- Exposes the counters to the 16-bit CPU through a small memory-mapped read/write port.
- Uses a hi/lo snapshot scheme so 32-bit counts are read coherently over a 16-bit bus.

Parameters:
- CNT_W, 32: counter width in bits; legal range 17..32; upper bits read as zero when CNT_W < 32.
- EN_RST, 1: value of the ctrl.enable bit after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- inc_br_cnt  in  1  one branch reached EX this cycle.
- inc_hit_cnt  in  1  BTB hit this cycle.
- inc_mispr_cnt  in  1  BTB misprediction this cycle.
- addr  in  3  register select.
- re  in  1  read strobe, one cycle per access.
- we  in  1  write strobe, one cycle per access.
- wdata  in  16  write data.
- rdata  out  16  read data, valid when rdata_vld=1.
- rdata_vld  out  1  one-cycle pulse, one cycle after re.

Behaviour:
- Reset, asynchronous on rst=1:
  - br_cnt, hit_cnt and mispr_cnt cleared to 0.
  - hi shadow cleared to 0.
  - ctrl.enable = EN_RST; ctrl.freeze = 0.
  - rdata = 16'h0000; rdata_vld = 0.
  - sat flags cleared to 0.
- Register map (addr):
  - 0 BR_LO, 1 BR_HI.
  - 2 HIT_LO, 3 HIT_HI.
  - 4 MISPR_LO, 5 MISPR_HI.
  - 6 CTRL: bit0 enable, bit1 freeze; R/W.
  - 7 STATUS: read bits[2:0] = sat flags {mispr, hit, br}. Write with bit0=1 = clear-all command.
- Counting:
  - Each counter increments by 1 on posedge when its strobe=1, ctrl.enable=1 and ctrl.freeze=0.
  - The three counters update independently; any combination of strobes may be high in the same cycle.
  - Saturation: a counter at all-ones stays all-ones and sets its sticky sat flag. It never wraps.
- Read protocol:
  - re sampled on posedge; rdata/rdata_vld registered, so latency is 1 cycle.
  - Reading any *_LO returns cnt[15:0] and, in the same cycle, latches cnt[CNT_W-1:16] of that counter into a single hi shadow.
  - Reading any *_HI returns the shadow, not the live value. Software reads LO then HI for a coherent 32-bit value.
  - HI read without a preceding LO read returns the stale shadow; this is legal.
  - rdata holds its last value when rdata_vld=0.
- Writes:
  - we sampled on posedge; no write response.
  - Writes to addr 0..5 are ignored (counters are read-only).
- Simultaneous events:
  - re and we both high: the write takes effect and the read returns the pre-write value.
  - Clear and a strobe in the same cycle: clear wins, the counter becomes 0 (not 1).
  - Clear also resets the sat flags and the hi shadow.
  - Read of LO in the same cycle as an increment returns the pre-increment value. The shadow captures the same pre-increment snapshot.
- Freeze: counters hold while freeze=1; reads remain fully functional. Strobes during freeze are lost, not queued.
- Reset mid-access: a pending read is dropped and rdata_vld is forced to 0.

Optional Feature:
- Macro: BR_STAT_IRQ_EN.
- When defined:
  - Adds output port stat_irq (1 bit), registered; reset value 0.
  - Adds CTRL bit2 irq_mask, reset 0.
  - stat_irq = |sat_flags & irq_mask; it asserts the cycle after the flag sets and stays high until clear-all.
- When undefined:
  - No stat_irq port.
  - CTRL bit2 reads 0 and ignores writes.

Test Plan:
- Reset, then read addr 0..7 -> rdata 0 for 0..5, CTRL=16'h0001, STATUS=0; rdata_vld exactly 1 cycle after each re.
- 10 cycles inc_br_cnt=1, 4 of them also inc_hit_cnt=1, 1 with inc_mispr_cnt=1 -> BR_LO=10, HIT_LO=4, MISPR_LO=1, all HI=0.
- Force br_cnt=32'h0000_FFFF, pulse inc_br_cnt, then read LO then HI -> 16'h0000 then 16'h0001; a further strobe between the LO and HI reads does not change the HI result.
- Force hit_cnt=32'hFFFF_FFFE, 3 strobes -> count 32'hFFFF_FFFF, STATUS=3'b010; with BR_STAT_IRQ_EN and mask=1, stat_irq=1 until a write of 16'h0001 to addr 7.
- Write CTRL=16'h0003 (freeze), 5 strobes -> counts unchanged. Then clear-all in the same cycle as inc_mispr_cnt -> MISPR_LO=0.
- Assert rst during a read (re the cycle before) -> rdata_vld=0, rdata=0, all counters 0 asynchronously before the next edge.
